// File: rtl/rf_write_arbiter.sv
// Purpose: round-robin share of the register-file write port between pipeline writeback (p0) and multi-cycle unit (p1), plus busy scoreboard.
// Latency: handshake at edge E drives rf_* during E..E+1; busy updates are visible the cycle after the setting/clearing edge.
// Backpressure: at most one ready per cycle; the loser keeps valid high and wins next cycle; ready is 0 while rst is high.
module rf_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   p0_valid,
  output logic                   p0_ready,
  input  logic [ADDR_W-1:0]      p0_rd,
  input  logic [DATA_W-1:0]      p0_data,
  input  logic                   p1_valid,
  output logic                   p1_ready,
  input  logic [ADDR_W-1:0]      p1_rd,
  input  logic [DATA_W-1:0]      p1_data,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_rd,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic                   rf_reg_write,
  output logic [ADDR_W-1:0]      rf_rd,
  output logic [DATA_W-1:0]      rf_write_data
);

  localparam int NREG = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic            last_grant;   // port that won the most recent transfer
  logic            p0_xfer;
  logic            p1_xfer;
  logic            wr_en_q;
  wr_t             wr_q;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;

  // Grant: a lone requester wins; on a tie the port that did not win last time wins.
  always_comb begin
    p0_ready = 1'b0;
    p1_ready = 1'b0;
    if (!rst) begin
      if (p0_valid && p1_valid) begin
        p0_ready = last_grant;
        p1_ready = !last_grant;
      end else begin
        p0_ready = p0_valid;
        p1_ready = p1_valid;
      end
    end
  end

  assign p0_xfer = p0_valid && p0_ready;
  assign p1_xfer = p1_valid && p1_ready;

  // Round-robin pointer moves only when a transfer actually happens; reset favours port 0 on the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (p0_xfer) begin
      last_grant <= 1'b0;
    end else if (p1_xfer) begin
      last_grant <= 1'b1;
    end
  end

  // Register the winning write; register 0 is read-only so its write enable is suppressed, address/data still load.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q <= 1'b0;
      wr_q    <= '0;
    end else if (p0_xfer) begin
      wr_en_q <= (p0_rd != '0);
      wr_q    <= '{rd: p0_rd, data: p0_data};
    end else if (p1_xfer) begin
      wr_en_q <= (p1_rd != '0);
      wr_q    <= '{rd: p1_rd, data: p1_data};
    end else begin
      wr_en_q <= 1'b0;
    end
  end

  // Scoreboard next state: p1 write clears, reservation sets afterwards so set wins on the same register; bit 0 never busy.
  always_comb begin
    busy_nxt = busy_q;
    if (p1_xfer) begin
      busy_nxt[p1_rd] = 1'b0;
    end
    if (rsv_valid && (rsv_rd != '0)) begin
      busy_nxt[rsv_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard state; reservations arriving during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy          = busy_q;
  assign rf_reg_write  = wr_en_q;
  assign rf_rd         = wr_q.rd;
  assign rf_write_data = wr_q.data;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Purpose: self-checking bench for rf_write_arbiter using an expected-write scoreboard queue.
// Latency: each expected write is pushed when the handshake is sampled and popped one edge later.
// Backpressure: requesters hold request fields until their own transfer, as required of callers.
module tb_rf_write_arbiter;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_valid, p1_valid, rsv_valid;
  logic [AW-1:0] p0_rd, p1_rd, rsv_rd;
  logic [DW-1:0] p0_data, p1_data;
  logic          p0_ready, p1_ready;
  logic [NR-1:0] busy;
  logic          rf_reg_write;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_write_data;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_rd(p0_rd), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_rd(p1_rd), .p1_data(p1_data),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .busy(busy),
    .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_write_data(rf_write_data)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state
  logic          m_lg   = 1'b1;
  logic [AW-1:0] m_rd   = '0;
  logic [DW-1:0] m_data = '0;
  logic [NR-1:0] m_busy = '0;

  // Readies observed at the most recent step
  logic obs_r0, obs_r1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: sample handshake at negedge, push expectation, compare after the edge.
  task automatic step();
    logic g0, g1;
    wr_t  e, got;
    logic [NR-1:0] nb;
    @(negedge clk);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (p0_valid && p1_valid) begin
        g0 = m_lg;
        g1 = !m_lg;
      end else begin
        g0 = p0_valid;
        g1 = p1_valid;
      end
    end
    obs_r0 = p0_ready;
    obs_r1 = p1_ready;
    check("p0_ready", {31'd0, p0_ready}, {31'd0, g0});
    check("p1_ready", {31'd0, p1_ready}, {31'd0, g1});
    nb = m_busy;
    if (rst) begin
      e = '0;
      nb = '0;
      m_lg = 1'b1;
    end else begin
      e = '{we: 1'b0, rd: m_rd, data: m_data};
      if (g0) begin
        e = '{we: (p0_rd != 0), rd: p0_rd, data: p0_data};
        m_lg = 1'b0;
      end else if (g1) begin
        e = '{we: (p1_rd != 0), rd: p1_rd, data: p1_data};
        m_lg = 1'b1;
        nb[p1_rd] = 1'b0;
      end
      if (rsv_valid && rsv_rd != 0) nb[rsv_rd] = 1'b1;
    end
    m_rd   = e.rd;
    m_data = e.data;
    m_busy = nb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("rf_reg_write",  {31'd0, rf_reg_write},   {31'd0, got.we});
    check("rf_rd",         {29'd0, rf_rd},          {29'd0, got.rd});
    check("rf_write_data", {16'd0, rf_write_data},  {16'd0, got.data});
    check("busy",          {24'd0, busy},           {24'd0, m_busy});
  endtask

  initial begin
    logic x0, x1;
    rst = 1'b1;
    p0_valid = 1'b1; p0_rd = 3'd1; p0_data = 16'hAAAA;
    p1_valid = 1'b1; p1_rd = 3'd2; p1_data = 16'hBBBB;
    rsv_valid = 1'b1; rsv_rd = 3'd4;

    // Reset with both requesting and a reservation pending
    step();
    step();
    check("rst_busy", {24'd0, busy}, 32'h00);
    check("rst_rfwe", {31'd0, rf_reg_write}, 32'd0);
    rsv_valid = 1'b0;
    rst = 1'b0;
    step();
    check("first_tie_p0", {31'd0, obs_r0}, 32'd1);
    p0_valid = 1'b0; p1_valid = 1'b0;
    step();

    // Single writer
    p0_valid = 1'b1; p0_rd = 3'd3; p0_data = 16'h1234;
    step();
    check("single_ready", {31'd0, obs_r0}, 32'd1);
    check("single_we",    {31'd0, rf_reg_write}, 32'd1);
    check("single_rd",    {29'd0, rf_rd}, 32'd3);
    check("single_data",  {16'd0, rf_write_data}, 32'h1234);
    p0_valid = 1'b0;
    step();
    check("single_we_off", {31'd0, rf_reg_write}, 32'd0);

    // Zero register: p1 write to r0 and reservation of r0
    p1_valid = 1'b1; p1_rd = 3'd0; p1_data = 16'hFFFF;
    rsv_valid = 1'b1; rsv_rd = 3'd0;
    step();
    check("r0_ready", {31'd0, obs_r1}, 32'd1);
    check("r0_we",    {31'd0, rf_reg_write}, 32'd0);
    check("r0_data",  {16'd0, rf_write_data}, 32'hFFFF);
    check("r0_busy",  {24'd0, busy}, 32'h00);
    rsv_valid = 1'b0; p1_valid = 1'b0;

    // Contention: alternate p0,p1,p0,p1 with no idle cycles
    p0_valid = 1'b1; p0_rd = 3'd1; p0_data = 16'hAAAA;
    p1_valid = 1'b1; p1_rd = 3'd2; p1_data = 16'hBBBB;
    for (int i = 0; i < 4; i++) begin
      step();
      check("cont_order", {31'd0, obs_r0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_we",    {31'd0, rf_reg_write}, 32'd1);
      check("cont_data",  {16'd0, rf_write_data}, (i % 2 == 0) ? 32'hAAAA : 32'hBBBB);
    end
    p0_valid = 1'b0; p1_valid = 1'b0;

    // Scoreboard set, clear, set-wins
    rsv_valid = 1'b1; rsv_rd = 3'd5;
    step();
    check("sb_set", {24'd0, busy}, 32'h20);
    rsv_valid = 1'b0;
    p1_valid = 1'b1; p1_rd = 3'd5; p1_data = 16'h5555;
    step();
    check("sb_clear", {24'd0, busy}, 32'h00);
    check("sb_clear_we", {31'd0, rf_reg_write}, 32'd1);
    p1_valid = 1'b0;
    rsv_valid = 1'b1; rsv_rd = 3'd5;
    step();
    p1_valid = 1'b1; p1_rd = 3'd5; p1_data = 16'h6666;
    step();
    check("sb_set_wins", {24'd0, busy}, 32'h20);
    rsv_valid = 1'b0;
    step();
    check("sb_clear2", {24'd0, busy}, 32'h00);
    p1_valid = 1'b0;

    // Reset mid-operation
    p0_valid = 1'b1; p0_rd = 3'd6; p0_data = 16'h0606;
    p1_valid = 1'b1; p1_rd = 3'd7; p1_data = 16'h0707;
    for (int i = 0; i < 6; i++) begin
      rsv_valid = (i % 2 == 0);
      rsv_rd = 3'($urandom_range(1, 7));
      step();
    end
    rsv_valid = 1'b1; rsv_rd = 3'd3;
    rst = 1'b1;
    step();
    check("mid_rst_ready", {30'd0, obs_r0, obs_r1}, 32'd0);
    check("mid_rst_busy",  {24'd0, busy}, 32'h00);
    check("mid_rst_we",    {31'd0, rf_reg_write}, 32'd0);
    rst = 1'b0; rsv_valid = 1'b0;
    step();
    check("post_rst_p0", {31'd0, obs_r0}, 32'd1);

    // Random traffic; requests held until transferred
    for (int i = 0; i < 400; i++) begin
      x0 = obs_r0;
      x1 = obs_r1;
      if (!p0_valid || x0) begin
        p0_valid = ($urandom_range(0, 99) < 60);
        p0_rd    = 3'($urandom_range(0, 7));
        p0_data  = 16'($urandom);
      end
      if (!p1_valid || x1) begin
        p1_valid = ($urandom_range(0, 99) < 60);
        p1_rd    = 3'($urandom_range(0, 7));
        p1_data  = 16'($urandom);
      end
      rsv_valid = ($urandom_range(0, 99) < 30);
      rsv_rd    = 3'($urandom_range(0, 7));
      rst       = ($urandom_range(0, 99) < 2);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
